// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared, fully pipelined 4-bit ALU.
// Tags each issued op so its result returns with the requester ID.
module alu_rr_arbiter #(
    parameter int ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_opcode,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_opcode,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy
);

    logic               rr_ptr;
    logic               grant0;
    logic               grant1;
    logic               xfer;
    logic               gid;
    logic [ALU_LAT-1:0] tag_v;
    logic [ALU_LAT-1:0] tag_id;

    // rr_ptr only matters when both requesters contend
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign gid        = grant1;

    // idle slots feed 0+0 so the ALU never sees stale operands
    always_comb begin
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        alu_opcode = 2'b00;
        if (grant0) begin
            alu_a      = req0_a;
            alu_b      = req0_b;
            alu_opcode = req0_opcode;
        end else if (grant1) begin
            alu_a      = req1_a;
            alu_b      = req1_b;
            alu_opcode = req1_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= ~gid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= xfer;
            tag_id[0] <= gid;
            for (int k = 1; k < ALU_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // tail tag lines up with the registered ALU result
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 8'd0;
        end else begin
            rsp_valid <= tag_v[ALU_LAT-1];
            if (tag_v[ALU_LAT-1]) begin
                rsp_id   <= tag_id[ALU_LAT-1];
                rsp_data <= alu_result;
            end
        end
    end

    assign busy = (|tag_v) | rsp_valid;

endmodule
